// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared async FIFO defaults and Gray/binary pointer conversions
package async_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PTR_WIDTH  = 3;

    // Width-agnostic up to 32 bits: callers zero-extend in and size-cast out.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int s = 1; s < 32; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_skid2.sv
// rtl/async_fifo_skid2.sv - two-entry skid buffer; head at slot0, push lands in first free slot after pop
module async_fifo_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [1:0]       count_q, count_d;
    logic [1:0]       count_after_pop;
    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;

    always_comb begin
        count_after_pop = count_q - {1'b0, pop_i};
        count_d         = count_after_pop + {1'b0, push_i};
        slot0_d         = slot0_q;
        slot1_d         = slot1_q;
        if (pop_i) begin
            slot0_d = slot1_q;
        end
        if (push_i) begin
            if (count_after_pop == 2'd0) begin
                slot0_d = push_data_i;
            end else begin
                slot1_d = push_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = slot0_q;

endmodule

// File: rtl/async_fifo_rd_stage.sv
// rtl/async_fifo_rd_stage.sv - async FIFO read-side stage: issues r_en, buffers memory data into a valid/ready stream, reports level
module async_fifo_rd_stage
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PTR_WIDTH  = DEF_PTR_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  empty,
    input  logic [PTR_WIDTH:0]    b_rptr,
    input  logic [PTR_WIDTH:0]    g_wptr_sync,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [PTR_WIDTH:0]    rd_level
);

    localparam int PW = PTR_WIDTH + 1;

    logic          inflight_q, inflight_d;
    logic [PW-1:0] rd_level_q, rd_level_d;
    logic [1:0]    count;
    logic [2:0]    occupancy;
    logic          pop;

    async_fifo_skid2 #(
        .WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i       (rclk),
        .rst_ni      (rrst_n),
        .push_i      (inflight_q),
        .push_data_i (rdata),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (m_data)
    );

    // Occupancy after this edge; the pop term lets a drained slot be refilled in the same cycle.
    always_comb begin
        m_valid    = (count != 2'd0);
        pop        = m_valid & m_ready;
        occupancy  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        r_en       = !empty && (occupancy < 3'd2);
        inflight_d = r_en;
        rd_level_d = PW'(gray2bin(32'(g_wptr_sync)) - 32'(b_rptr));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_q <= 1'b0;
            rd_level_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_level_q <= rd_level_d;
        end
    end

    assign rd_level = rd_level_q;

endmodule

// File: doc/async_fifo_rd_stage.md
# async_fifo_rd_stage

Read-side output stage of the async FIFO, in the rclk domain directly downstream of the read-pointer handler and the dual-port memory. It converts the handler's registered `empty` flag and the memory's registered read data into a valid/ready stream, and it is the only driver of `r_en`. It holds a 2-entry skid buffer so that consumer backpressure never stalls pointer logic mid-read. It also reports the registered number of words still stored in the FIFO memory.

## Interface
- DATA_WIDTH, 8, payload width
- PTR_WIDTH, 3, pointer width; FIFO depth is 2**PTR_WIDTH, pointers are PTR_WIDTH+1 bits
- rclk  in  1  read-domain clock
- rrst_n  in  1  reset; asynchronous, active-low
- empty  in  1  registered empty flag from the read-pointer handler
- b_rptr  in  PTR_WIDTH+1  binary read pointer from the handler
- g_wptr_sync  in  PTR_WIDTH+1  Gray write pointer, already synchronized into rclk
- rdata  in  DATA_WIDTH  memory read data; registered in the memory on the rclk edge that samples r_en=1
- r_en  out  1  read request to handler and memory (combinational)
- m_valid  out  1  output data valid
- m_data  out  DATA_WIDTH  output data (head of skid buffer)
- m_ready  in  1  consumer accept
- rd_level  out  PTR_WIDTH+1  registered count of unread words in memory (0..2**PTR_WIDTH)

## Operation
- State:
  - `inflight`: 1 bit, set when a read was issued last cycle.
  - `count`: 0..2, number of skid-buffer entries.
  - `slot0` and `slot1`: buffer entries; slot0 is the head.
- pop = m_valid & m_ready.
- Issue rule: r_en = !empty & ((count + inflight - pop) < 2). r_en is never high while empty=1. Underflow is impossible by construction.
- r_en depends combinationally on m_ready. This gives full throughput: 1 word/cycle sustained with m_ready held high.
- Landing: when inflight=1, rdata is written into the first free slot in the same edge that applies pop.
  - Pop shifts slot1 into slot0.
  - If pop and landing coincide with count=1, rdata goes into slot0.
- count_next = count + inflight - pop. inflight_next = r_en.
- m_valid = (count != 0). m_data = slot0. m_data holds its value while m_valid & !m_ready.
- rd_level = gray2bin(g_wptr_sync) - b_rptr, modulo 2**(PTR_WIDTH+1), registered every cycle. It excludes words held in the skid buffer or in flight.
- Reset values: inflight=0, count=0, m_valid=0, m_data=0, slot1=0, rd_level=0. r_en=0 throughout reset because the handler holds empty=1.
- Reset mid-operation clears the buffer and inflight immediately. In-flight and buffered data are discarded and no m_valid glitch occurs. The handler's pointers reset concurrently.

## Timing
- Empty-to-valid latency is 2 rclk edges:
  - empty falls after edge E0, so r_en=1 in the following cycle.
  - rdata is valid after E1.
  - m_valid=1 after E2.
- Ready-to-valid: an entry already buffered is presented with 0 additional latency after pop.
- Backpressure: with m_ready=0, at most 2 words are fetched (count+inflight ≤ 2), then r_en=0 until a pop.
- When m_ready rises with count=2, r_en re-asserts in that same cycle (the pop term).
- Pointer wrap-around: rd_level is correct across the MSB wrap of both pointers through modular subtraction. A full FIFO reports 2**PTR_WIDTH.
- rd_level lags the true level by 1 cycle beyond synchronizer latency. It can only overstate free space on the write side, never invent data on this side.

## Structure
- Shared package `async_fifo_pkg`:
  - default PTR_WIDTH and DATA_WIDTH;
  - function gray2bin (also used by the write-side full logic);
  - function bin2gray.
- One sub-module: `async_fifo_skid2`, the 2-entry buffer. It holds count and the slots, with push/pop/data ports and no FIFO knowledge.
- The issue logic and rd_level stay in the top.

## Test plan
- Reset: hold rrst_n=0 with empty=1 -> r_en=0, m_valid=0, m_data=0, rd_level=0; after release, all outputs stay 0.
- Single word: drive empty 1->0 for one read, rdata=8'hA5, m_ready=1 -> r_en high for exactly 1 cycle; m_valid high 2 edges later with m_data=8'hA5 for 1 cycle.
- Streaming: 8 words 0x01..0x08, m_ready=1 -> r_en high 8 consecutive cycles; m_valid high 8 consecutive cycles; data in order, no gaps.
- Backpressure: stream with m_ready=0 -> exactly 2 r_en pulses, then r_en=0 and m_data held at first word. Raise m_ready -> r_en re-asserts in the same cycle; all words delivered in order with none lost or duplicated.
- Level and wrap: g_wptr_sync=bin2gray(4'b0010), b_rptr=4'b1110 -> rd_level=4 one cycle later. g_wptr_sync=bin2gray(4'b1110), b_rptr=4'b0110 -> rd_level=8.
- Mid-stream reset: assert rrst_n with count=2 and inflight=1 -> m_valid=0 asynchronously; after release, first m_data comes only from a fresh read.
